mdu_core: RTL and testbench

MDU_CORE -- requirements
Module: mdu_core

---
 rtl/mdu_core.sv | 200 ++++++++++++++++++++
 tb/tb_mdu_core.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mdu_core.sv
// Multiply/divide unit with architectural HI/LO, fixed-latency multi-cycle ops.
// Optional multiply-accumulate (op 6/7) enabled by defining MDU_MADD_EN.
module mdu_core #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_MADDU = 3'd7
    } op_e;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

`ifdef MDU_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    state_e      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    op_e         op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;

    op_e  op_in;
    logic is_mul_op;
    logic is_div_op;
    logic accept;

    always_comb begin
        op_in     = op_e'(op);
        is_mul_op = (op_in == OP_MULT) || (op_in == OP_MULTU) ||
                    (MADD_EN && ((op_in == OP_MADD) || (op_in == OP_MADDU)));
        is_div_op = (op_in == OP_DIV) || (op_in == OP_DIVU);
        accept    = start & ~flush & ~busy_q;
        stall_req = busy_q | (start & ~flush & (is_mul_op | is_div_op));
    end

    // One 64x64 multiplier serves both signednesses: operands are sign- or
    // zero-extended first, and only the low 64 bits of the product are kept.
    logic        mul_signed;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;
    logic [63:0] acc_sum;

    always_comb begin
        mul_signed = (op_q == OP_MULT) || (op_q == OP_MADD);
        mul_a      = {(mul_signed ? {32{a_q[31]}} : 32'h0), a_q};
        mul_b      = {(mul_signed ? {32{b_q[31]}} : 32'h0), b_q};
        product    = mul_a * mul_b;
        acc_sum    = {hi_q, lo_q} + product;
    end

    // Signed divide via magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
    logic        div_signed;
    logic        a_neg;
    logic        b_neg;
    logic        b_zero;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] divisor;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    always_comb begin
        div_signed = (op_q == OP_DIV);
        a_neg      = div_signed & a_q[31];
        b_neg      = div_signed & b_q[31];
        b_zero     = (b_q == '0);
        a_mag      = a_neg ? (32'h0 - a_q) : a_q;
        b_mag      = b_neg ? (32'h0 - b_q) : b_q;
        divisor    = b_zero ? 32'h1 : b_mag;
        quo_mag    = a_mag / divisor;
        rem_mag    = a_mag % divisor;
        quo        = (a_neg ^ b_neg) ? (32'h0 - quo_mag) : quo_mag;
        rem        = a_neg ? (32'h0 - rem_mag) : rem_mag;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_mul_op || is_div_op) begin
                        state_d = S_RUN;
                        cnt_d   = is_mul_op ? MULT_LOAD : DIV_LOAD;
                        op_d    = op_in;
                        a_d     = A;
                        b_d     = B;
                        busy_d  = 1'b1;
                    end else if (op_in == OP_MTHI) begin
                        hi_d = A;
                    end else if (op_in == OP_MTLO) begin
                        lo_d = A;
                    end
                end
            end
            S_RUN: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    case (op_q)
                        OP_MULT, OP_MULTU: begin
                            hi_d = product[63:32];
                            lo_d = product[31:0];
                        end
                        OP_MADD, OP_MADDU: begin
                            if (MADD_EN) begin
                                hi_d = acc_sum[63:32];
                                lo_d = acc_sum[31:0];
                            end
                        end
                        OP_DIV, OP_DIVU: begin
                            if (!b_zero) begin
                                hi_d = rem;
                                lo_d = quo;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    assign busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_core.sv
// Directed-vector bench for mdu_core; MDU_MADD_EN selects the madd vectors.
module tb_mdu_core;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy;
    logic        stall_req;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_vec = 0;
    int n_err = 0;

    mdu_core #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .A        (A),
        .B        (B),
        .flush    (flush),
        .busy     (busy),
        .stall_req(stall_req),
        .HI       (HI),
        .LO       (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 1 tries an mthi while busy; mode 2 holds flush high through the run
    task automatic run_to_done(input string tag, input int exp_cyc, input int mode,
                               input logic [31:0] hold_hi, input logic [31:0] hold_lo);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            check({tag, "_hold_hi"}, 64'(HI), 64'(hold_hi));
            check({tag, "_hold_lo"}, 64'(LO), 64'(hold_lo));
            if (n == 0)
                check({tag, "_stall"}, 64'(stall_req), 64'd1);
            A = $urandom;
            B = $urandom;
            if (mode == 1 && n == 1) begin
                start = 1'b1;
                op    = 3'd4;
                A     = 32'h12345678;
            end else begin
                start = 1'b0;
            end
            flush = (mode == 2);
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        flush = 1'b0;
        check({tag, "_cycles"}, 64'(n), 64'(exp_cyc));
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] ehi, input logic [31:0] elo);
        check({tag, "_hi"}, 64'(HI), 64'(ehi));
        check({tag, "_lo"}, 64'(LO), 64'(elo));
    endtask

    initial begin
        // Reset values
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check_hilo("rst", 32'h0, 32'h0);

        // First accept on the first edge after release
        @(negedge clk);
        reset_n = 1'b1;
        start   = 1'b1;
        op      = 3'd4;
        A       = 32'h11111111;
        @(negedge clk);
        start = 1'b0;
        check("first_mthi", 64'(HI), 64'h11111111);

        issue(3'd5, 32'h22222222, 32'h0);
        check_hilo("mtlo", 32'h11111111, 32'h22222222);
        check("mtlo_busy", 64'(busy), 64'd0);

        // stall_req decode and flushed start
        @(negedge clk);
        start = 1'b1; op = 3'd0; flush = 1'b0;
        #1 check("stall_mult", 64'(stall_req), 64'd1);
        op = 3'd3;
        #1 check("stall_divu", 64'(stall_req), 64'd1);
        op = 3'd4;
        #1 check("stall_mthi", 64'(stall_req), 64'd0);
        op = 3'd0; flush = 1'b1;
        #1 check("stall_flush", 64'(stall_req), 64'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check_hilo("flush", 32'h11111111, 32'h22222222);

        issue(3'd0, 32'hFFFFFFFE, 32'd3);
        run_to_done("mult", 5, 1, 32'h11111111, 32'h22222222);
        check_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);

        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_to_done("multu", 5, 0, 32'hFFFFFFFF, 32'hFFFFFFFA);
        check_hilo("multu", 32'hFFFFFFFE, 32'h00000001);

        issue(3'd0, 32'h80000000, 32'h80000000);
        run_to_done("mult_min", 5, 0, 32'hFFFFFFFE, 32'h00000001);
        check_hilo("mult_min", 32'h40000000, 32'h0);

        issue(3'd3, 32'd7, 32'd2);
        run_to_done("divu", 10, 0, 32'h40000000, 32'h0);
        check_hilo("divu", 32'd1, 32'd3);

        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        run_to_done("div_neg", 10, 0, 32'd1, 32'd3);
        check_hilo("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);

        issue(3'd2, 32'd5, 32'd0);
        run_to_done("div_zero", 10, 0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        check_hilo("div_zero", 32'hFFFFFFFF, 32'hFFFFFFFD);

        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        run_to_done("div_ovf", 10, 0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        check_hilo("div_ovf", 32'h0, 32'h80000000);

        issue(3'd2, 32'd7, 32'hFFFFFFFE);
        run_to_done("div_negb", 10, 0, 32'h0, 32'h80000000);
        check_hilo("div_negb", 32'd1, 32'hFFFFFFFD);

        issue(3'd3, 32'd100, 32'd7);
        run_to_done("divu_flush", 10, 2, 32'd1, 32'hFFFFFFFD);
        check_hilo("divu_flush", 32'd2, 32'd14);

`ifdef MDU_MADD_EN
        issue(3'd4, 32'h0, 32'h0);
        issue(3'd5, 32'd5, 32'h0);
        issue(3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_to_done("maddu", 5, 0, 32'h0, 32'd5);
        check_hilo("maddu", 32'hFFFFFFFE, 32'h00000006);

        issue(3'd6, 32'hFFFFFFFE, 32'd3);
        run_to_done("madd", 5, 0, 32'hFFFFFFFE, 32'h00000006);
        check_hilo("madd", 32'hFFFFFFFE, 32'h00000000);
`else
        @(negedge clk);
        start = 1'b1; op = 3'd6; A = 32'd3; B = 32'd3;
        #1 check("madd_off_stall", 64'(stall_req), 64'd0);
        @(negedge clk);
        op = 3'd7;
        check("madd_off_busy", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0;
        check("maddu_off_busy", 64'(busy), 64'd0);
        check_hilo("madd_off", 32'd2, 32'd14);
`endif

        // Reset in the third busy cycle of a div discards it
        issue(3'd2, 32'd100, 32'd7);
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_busy_pre", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_busy", 64'(busy), 64'd0);
        check_hilo("rst_mid", 32'h0, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        check("rst_after_busy", 64'(busy), 64'd0);
        check_hilo("rst_after", 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
